// File: rtl/dowave_pkg.sv
// dowave_pkg: shared definitions for the LED wand frame sequencer.
//   word_t  - word type codes driven on led_type (START / LED / END)
//   mode_t  - ramp modes sampled from dowave_mode (code 3 behaves as hold)
//   state_t - sequencer FSM states
package dowave_pkg;

    typedef enum logic [1:0] {
        TYPE_START = 2'd0,
        TYPE_LED   = 2'd1,
        TYPE_END   = 2'd2
    } word_t;

    typedef enum logic [1:0] {
        MODE_WRAP = 2'd0,
        MODE_TRI  = 2'd1,
        MODE_HOLD = 2'd2
    } mode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_GAP,
        ST_START1,
        ST_START2,
        ST_WAIT
    } state_t;

endpackage

// File: rtl/dowave_seq_if.sv
// dowave_seq_if: word handshake between the sequencer and the doled driver.
//   led_start                     - word start strobe (two cycles high)
//   led_type                      - word type code (dowave_pkg::word_t)
//   led_red/led_green/led_blue    - colour of the current word
//   doled_busy                    - driver busy, returned by doled
// master: sequencer side, slave: driver side.
interface dowave_seq_if #(
    parameter int unsigned CH_WIDTH = 8
);
    logic                led_start;
    logic [1:0]          led_type;
    logic [CH_WIDTH-1:0] led_red;
    logic [CH_WIDTH-1:0] led_green;
    logic [CH_WIDTH-1:0] led_blue;
    logic                doled_busy;

    modport master (
        output led_start, led_type, led_red, led_green, led_blue,
        input  doled_busy
    );

    modport slave (
        input  led_start, led_type, led_red, led_green, led_blue,
        output doled_busy
    );
endinterface

// File: rtl/dowave_channel.sv
// dowave_channel: one colour ramp engine.
//   dowave_clk, dowave_reset - clock, async active-high reset
//   update                   - advance the ramp by one step this cycle
//   mode                     - wrap / triangle / hold (anything else holds)
//   index                    - added to STEP to form the increment
//   value                    - current channel value (registered)
module dowave_channel
    import dowave_pkg::*;
#(
    parameter int unsigned CH_WIDTH  = 8,
    parameter int unsigned STEP      = 10,
    parameter int unsigned MIN       = 0,
    parameter int unsigned MAX       = 200,
    parameter int unsigned IDX_WIDTH = 3
) (
    input  logic                 dowave_clk,
    input  logic                 dowave_reset,
    input  logic                 update,
    input  mode_t                mode,
    input  logic [IDX_WIDTH-1:0] index,
    output logic [CH_WIDTH-1:0]  value
);

    localparam int unsigned W1 = CH_WIDTH + 1;
    localparam logic [CH_WIDTH-1:0] MIN_V = CH_WIDTH'(MIN);
    localparam logic [CH_WIDTH-1:0] MAX_V = CH_WIDTH'(MAX);

    logic [W1-1:0]       inc_raw;
    logic [W1-1:0]       sum_raw;
    logic [W1-1:0]       low_lim;
    logic [CH_WIDTH-1:0] inc;
    logic [CH_WIDTH-1:0] sum_sat;
    logic                dir_down;

    // All sums carry one extra bit so overflow saturates instead of wrapping.
    always_comb begin
        inc_raw = W1'(STEP) + W1'(index);
        inc     = inc_raw[CH_WIDTH] ? '1 : inc_raw[CH_WIDTH-1:0];
        sum_raw = {1'b0, value} + {1'b0, inc};
        sum_sat = sum_raw[CH_WIDTH] ? '1 : sum_raw[CH_WIDTH-1:0];
        low_lim = {1'b0, MIN_V} + {1'b0, inc};
    end

    always_ff @(posedge dowave_clk or posedge dowave_reset) begin
        if (dowave_reset) begin
            value    <= '0;
            dir_down <= 1'b0;
        end else if (update) begin
            case (mode)
                MODE_WRAP: begin
                    if (value >= MAX_V) value <= MIN_V;
                    else                value <= sum_sat;
                end
                MODE_TRI: begin
                    if (!dir_down) begin
                        if (sum_raw >= {1'b0, MAX_V}) begin
                            value    <= MAX_V;
                            dir_down <= 1'b1;
                        end else begin
                            value <= sum_sat;
                        end
                    end else begin
                        if ({1'b0, value} <= low_lim) begin
                            value    <= MIN_V;
                            dir_down <= 1'b0;
                        end else begin
                            value <= value - inc;
                        end
                    end
                end
                default: value <= value;
            endcase
        end
    end

endmodule

// File: rtl/dowave_seq.sv
// dowave_seq: frame sequencer for the LED wand, feeding the doled driver.
// Each frame: one START word, NUM_LEDS LED words, one END word.
//   dowave_clk    - clock
//   dowave_reset  - async active-high reset
//   dowave_enable - run frames while high (checked at frame boundaries)
//   dowave_mode   - ramp mode, latched when the START word is loaded
//   led           - word handshake to doled (master side)
//   frame_pulse   - one-cycle pulse when the END word starts
//   frame_count   - completed frames, wraps
module dowave_seq
    import dowave_pkg::*;
#(
    parameter int unsigned NUM_LEDS    = 6,
    parameter int unsigned CH_WIDTH    = 8,
    parameter int unsigned GAP_CYCLES  = 200,
    parameter int unsigned INDEX_SKEW  = 1,
    parameter int unsigned RED_STEP    = 10,
    parameter int unsigned RED_MIN     = 0,
    parameter int unsigned RED_MAX     = 200,
    parameter int unsigned GREEN_STEP  = 2,
    parameter int unsigned GREEN_MIN   = 40,
    parameter int unsigned GREEN_MAX   = 200,
    parameter int unsigned BLUE_STEP   = 5,
    parameter int unsigned BLUE_MIN    = 10,
    parameter int unsigned BLUE_MAX    = 200
) (
    input  logic          dowave_clk,
    input  logic          dowave_reset,
    input  logic          dowave_enable,
    input  logic [1:0]    dowave_mode,
    dowave_seq_if.master  led,
    output logic          frame_pulse,
    output logic [15:0]   frame_count
);

    localparam int unsigned IDX_W = $clog2(NUM_LEDS + 1);
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

    state_t           state;
    word_t            next_type;
    mode_t            mode_q;
    logic [IDX_W-1:0] index;
    logic [GAP_W-1:0] gap_cnt;
    logic             ch_update;
    logic [IDX_W-1:0] ch_index;

    // Channels advance on the same edge that loads an LED word, using that
    // word's index, so colours and led_type change together.
    assign ch_update = (state == ST_LOAD) && (next_type == TYPE_LED);
    assign ch_index  = (INDEX_SKEW != 0) ? index : '0;

    always_ff @(posedge dowave_clk or posedge dowave_reset) begin
        if (dowave_reset) begin
            state         <= ST_IDLE;
            next_type     <= TYPE_START;
            mode_q        <= MODE_WRAP;
            index         <= '0;
            gap_cnt       <= '0;
            led.led_start <= 1'b0;
            led.led_type  <= TYPE_START;
            frame_pulse   <= 1'b0;
            frame_count   <= '0;
        end else begin
            frame_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (dowave_enable && !led.doled_busy) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    led.led_type <= next_type;
                    gap_cnt      <= '0;
                    state        <= ST_GAP;
                    case (next_type)
                        TYPE_START: begin
                            mode_q    <= mode_t'(dowave_mode);
                            index     <= '0;
                            next_type <= TYPE_LED;
                        end
                        TYPE_LED: begin
                            if (index == IDX_W'(NUM_LEDS - 1)) begin
                                index     <= '0;
                                next_type <= TYPE_END;
                            end else begin
                                index <= index + 1'b1;
                            end
                        end
                        default: next_type <= TYPE_START;
                    endcase
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        state         <= ST_START1;
                        led.led_start <= 1'b1;
                        if (led.led_type == TYPE_END) begin
                            frame_pulse <= 1'b1;
                            frame_count <= frame_count + 16'd1;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                ST_START1: state <= ST_START2;
                ST_START2: begin
                    led.led_start <= 1'b0;
                    if (led.led_type == TYPE_END && !dowave_enable) state <= ST_IDLE;
                    else                                            state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!led.doled_busy) state <= ST_LOAD;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    dowave_channel #(
        .CH_WIDTH(CH_WIDTH), .STEP(RED_STEP), .MIN(RED_MIN), .MAX(RED_MAX), .IDX_WIDTH(IDX_W)
    ) u_red (
        .dowave_clk(dowave_clk), .dowave_reset(dowave_reset), .update(ch_update),
        .mode(mode_q), .index(ch_index), .value(led.led_red)
    );

    dowave_channel #(
        .CH_WIDTH(CH_WIDTH), .STEP(GREEN_STEP), .MIN(GREEN_MIN), .MAX(GREEN_MAX), .IDX_WIDTH(IDX_W)
    ) u_green (
        .dowave_clk(dowave_clk), .dowave_reset(dowave_reset), .update(ch_update),
        .mode(mode_q), .index(ch_index), .value(led.led_green)
    );

    dowave_channel #(
        .CH_WIDTH(CH_WIDTH), .STEP(BLUE_STEP), .MIN(BLUE_MIN), .MAX(BLUE_MAX), .IDX_WIDTH(IDX_W)
    ) u_blue (
        .dowave_clk(dowave_clk), .dowave_reset(dowave_reset), .update(ch_update),
        .mode(mode_q), .index(ch_index), .value(led.led_blue)
    );

endmodule

// File: tb/tb_dowave_seq.sv
// tb_dowave_seq: directed bench for dowave_seq with default parameters.
// A negedge monitor records every word at its led_start rising edge; the
// main sequence compares recorded words and outputs against hand-computed
// values.
module tb_dowave_seq;

    logic        dowave_clk    = 1'b0;
    logic        dowave_reset  = 1'b1;
    logic        dowave_enable = 1'b0;
    logic [1:0]  dowave_mode   = 2'd0;
    logic        frame_pulse;
    logic [15:0] frame_count;

    dowave_seq_if #(.CH_WIDTH(8)) led_if();

    dowave_seq #(
        .NUM_LEDS(6),
        .CH_WIDTH(8),
        .GAP_CYCLES(200)
    ) dut (
        .dowave_clk(dowave_clk),
        .dowave_reset(dowave_reset),
        .dowave_enable(dowave_enable),
        .dowave_mode(dowave_mode),
        .led(led_if),
        .frame_pulse(frame_pulse),
        .frame_count(frame_count)
    );

    always #5 dowave_clk = ~dowave_clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // word monitor
    logic [1:0] wtype[$];
    logic [7:0] wred[$];
    logic [7:0] wgrn[$];
    logic       start_q = 1'b0;
    int         npulse  = 0;

    always @(negedge dowave_clk) begin
        if (led_if.led_start && !start_q) begin
            wtype.push_back(led_if.led_type);
            wred.push_back(led_if.led_red);
            wgrn.push_back(led_if.led_green);
        end
        start_q = led_if.led_start;
        if (frame_pulse) npulse++;
    end

    task automatic wait_words(input int n, input int budget);
        int c = 0;
        while (wtype.size() < n && c < budget) begin
            @(negedge dowave_clk);
            #1;
            c++;
        end
        if (wtype.size() < n) chk("wait_words_timeout", wtype.size(), n);
    endtask

    logic [1:0] typ1 [8] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
    int         red1 [6] = '{10, 21, 33, 46, 60, 75};
    int         grn1 [6] = '{2, 5, 9, 14, 20, 27};

    initial begin
        int first;
        int viol;
        int changes;
        logic [7:0] s_red, s_grn, s_blu;
        logic [1:0] s_type;
        logic [15:0] s_fc;

        led_if.doled_busy = 1'b0;

        // reset state
        repeat (3) @(negedge dowave_clk);
        chk("rst_start", led_if.led_start, 0);
        chk("rst_type",  led_if.led_type, 0);
        chk("rst_red",   led_if.led_red, 0);
        chk("rst_green", led_if.led_green, 0);
        chk("rst_blue",  led_if.led_blue, 0);
        chk("rst_pulse", frame_pulse, 0);
        chk("rst_count", frame_count, 0);

        // frame 1, wrap mode, first-word latency
        dowave_enable = 1'b1;
        dowave_reset  = 1'b0;
        first = 0;
        for (int n = 1; n <= 400; n++) begin
            @(negedge dowave_clk);
            #1;
            if (led_if.led_start) begin
                first = n;
                break;
            end
        end
        chk("first_start_edge", first, 202);

        wait_words(8, 3000);
        chk("f1_count", frame_count, 1);
        for (int i = 0; i < 8; i++) chk($sformatf("f1_type%0d", i), wtype[i], typ1[i]);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("f1_red%0d", i),   wred[i+1], red1[i]);
            chk($sformatf("f1_green%0d", i), wgrn[i+1], grn1[i]);
        end
        chk("f1_end_red", wred[7], 75);

        // wrap boundary in frame 3, restart from MIN in frame 4
        wait_words(24, 4000);
        chk("f3_led4_red", wred[21], 210);
        chk("f3_led5_red", wred[22], 0);
        wait_words(25, 3000);
        dowave_mode = 2'd2;               // mid-frame change must be ignored
        wait_words(26, 3000);
        chk("f4_led0_red", wred[25], 10);
        wait_words(29, 3000);
        dowave_mode = 2'd1;               // triangle from frame 5

        // triangle: clamp at MAX, descend, clamp at MIN, climb again
        wait_words(47, 4000);
        chk("f6_led4_red", wred[45], 200);
        chk("f6_led5_red", wred[46], 185);
        wait_words(71, 6000);
        chk("f9_led2_red", wred[67], 2);
        chk("f9_led3_red", wred[68], 0);
        chk("f9_led4_red", wred[69], 14);
        chk("f9_led5_red", wred[70], 29);
        viol = 0;
        for (int i = 32; i < 71; i++) if (wred[i] > 8'd200) viol++;
        chk("tri_range", viol, 0);

        // enable drops mid-frame 10
        wait_words(73, 3000);
        chk("f10_count_before", frame_count, 9);
        wait_words(75, 3000);
        dowave_enable = 1'b0;
        chk("f10_led0_red", wred[73], 39);
        wait_words(80, 3000);
        chk("f10_end_type", wtype[79], 2);
        chk("f10_led5_red", wred[78], 104);
        chk("f10_count", frame_count, 10);
        repeat (1000) @(negedge dowave_clk);
        chk("park_words", wtype.size(), 80);
        chk("park_count", frame_count, 10);
        chk("park_pulses", npulse, 10);
        chk("park_start", led_if.led_start, 0);

        // busy stall in WAIT
        dowave_enable = 1'b1;
        wait_words(82, 3000);
        chk("f11_led0_red", wred[81], 114);
        @(negedge dowave_clk);            // START2
        led_if.doled_busy = 1'b1;
        @(negedge dowave_clk);            // WAIT
        s_red = led_if.led_red; s_grn = led_if.led_green; s_blu = led_if.led_blue;
        s_type = led_if.led_type; s_fc = frame_count;
        changes = 0;
        repeat (1000) begin
            @(negedge dowave_clk);
            if (led_if.led_start || led_if.led_red !== s_red || led_if.led_green !== s_grn ||
                led_if.led_blue !== s_blu || led_if.led_type !== s_type ||
                frame_count !== s_fc || frame_pulse) changes++;
        end
        chk("stall_changes", changes, 0);
        chk("stall_words", wtype.size(), 82);
        led_if.doled_busy = 1'b0;
        wait_words(83, 3000);
        chk("resume_type", wtype[82], 1);
        chk("resume_red", wred[82], 125);

        // async reset during START1 of the next word
        wait_words(84, 3000);
        dowave_reset = 1'b1;
        #1;
        chk("arst_start", led_if.led_start, 0);
        chk("arst_type",  led_if.led_type, 0);
        chk("arst_red",   led_if.led_red, 0);
        chk("arst_green", led_if.led_green, 0);
        chk("arst_count", frame_count, 0);
        dowave_mode = 2'd0;
        repeat (2) @(negedge dowave_clk);
        dowave_reset = 1'b0;
        wait_words(85, 3000);
        chk("post_rst_type", wtype[84], 0);
        wait_words(86, 3000);
        chk("post_rst_led0_type", wtype[85], 1);
        chk("post_rst_led0_red", wred[85], 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
